bshift8_cmd_feeder: RTL
=======================

// Module: bshift8_cmd_feeder
// PURPOSE
//  Upstream command stage for the 8-bit right-rotate barrel shifter.
//  - Buffers rotate commands in a small FIFO.
//  - Converts left rotates into the equivalent right-rotate amount.
//  - Drives the shifter's data and select inputs once per pass, feeding each result back for repeated passes.
//  - Returns the final word on a valid/ready result port.
//  The shifter is a peer instance connected through the sh_* ports. It is not instantiated inside this block.
// PARAMETERS
//  DEPTH  4  command FIFO entries; power of two, >=2
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command FIFO can accept
//  cmd_data   in   8   word to rotate
//  cmd_amt    in   3   rotate amount per pass, 0..7
//  cmd_dir    in   1   0 = right, 1 = left
//  cmd_rep    in   2   extra passes; total passes = cmd_rep + 1
//  sh_in      out  8   to shifter data input
//  sh_s       out  3   to shifter select (right-rotate amount)
//  sh_op      in   8   from shifter output (combinational, same cycle)
//  res_valid  out  1   result available
//  res_ready  in   1   result consumer accepts
//  res_data   out  8   rotated word
//  busy       out  1   FSM not in IDLE, or FIFO non-empty
//  level      out  $clog2(DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  - Reset (rst high at an edge):
//    - FIFO is emptied; FSM goes to IDLE.
//    - res_valid = 0, res_data = 0, level = 0, busy = 0.
//    - sh_in = 0, sh_s = 0.
//    - cmd_ready is held 0 while rst is high, and is 1 on the first cycle after reset.
//    - Reset mid-operation discards the in-flight command and all queued commands. No result is emitted for them.
//  - Accept: push on cmd_valid & cmd_ready.
//    - cmd_ready = (level != DEPTH), purely from registered count.
//    - When full, a pop in the same cycle does NOT open the slot; ready stays 0 that cycle.
//    - Simultaneous push and pop when not full: level unchanged.
//  - FIFO entry holds {data, s_eff, rep}, where s_eff = cmd_dir ? (3'd0 - cmd_amt) : cmd_amt. Arithmetic is mod 8.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: sh_in = 0, sh_s = 0. If FIFO is non-empty: pop the head into work regs {wdata, ws, wcnt = rep}, then go to RUN.
//    - RUN: sh_in = wdata, sh_s = ws.
//      - Each edge: wdata <= sh_op.
//      - If wcnt == 0: res_data <= sh_op, res_valid <= 1, go to DONE.
//      - Else: wcnt <= wcnt - 1 and stay in RUN.
//    - DONE: sh_in = 0, sh_s = 0. Hold res_data and res_valid stable until res_ready.
//      - On res_valid & res_ready: res_valid <= 0, go to IDLE.
//  - Latency: command accepted at edge E0 into an empty, idle block gives res_valid high after edge E0 + cmd_rep + 2.
//  - Throughput: one command per (cmd_rep + 3) cycles with res_ready tied high.
//  - Ordering: results appear strictly in command order. No command is dropped or duplicated.
//  - res_data changes only on the RUN -> DONE transition.
//  - busy is combinational: (state != IDLE) | (level != 0).
// STRUCTURE
//  - Shared package bshift_pkg:
//    - state enum {IDLE, RUN, DONE}.
//    - DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1.
//    - ROT_W = 8, AMT_W = 3, REP_W = 2.
//    - FIFO entry struct {data, s_eff, rep}.
//  - One sub-module: bshift_cmd_fifo.
//    - Synchronous FIFO, parameter DEPTH, width 13.
//    - Ports: push, pop, din, dout, full, empty, count.
//    - Pointer wrap is at DEPTH.
//  - The FSM, work regs and direction conversion live in this module.
// TESTING (bench instantiates this block and the 8-bit shifter, wired via sh_*)
//  - 0x96, amt 1, right, rep 0 -> res 0x4B. res_valid rises 2 cycles after accept.
//  - 0x96, amt 1, left, rep 0 -> sh_s = 7, res 0x2D. Also 0x5A, amt 0, left -> sh_s = 0, res 0x5A.
//  - 0x01, amt 3, right, rep 2 -> three passes (0x20, 0x04, 0x80) -> res 0x80, 4 cycles after accept.
//  - res_ready low, push DEPTH+1 commands -> level reaches DEPTH and cmd_ready drops.
//    Release res_ready -> all results arrive in order, none lost.
//  - rst pulsed while in RUN with 2 queued -> next cycle: level 0, res_valid 0, sh_s 0. No stale result afterwards.
//  - Random data, amt, dir and rep for 1000 commands with random res_ready -> results match reference rotate-mod-8 model.

Source files
------------

// File: rtl/bshift_pkg.sv
// Shared types and constants for the 8-bit rotate command feeder.
package bshift_pkg;

    localparam int unsigned ROT_W   = 8;
    localparam int unsigned AMT_W   = 3;
    localparam int unsigned REP_W   = 2;
    localparam int unsigned ENTRY_W = ROT_W + AMT_W + REP_W;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROT_W-1:0] data;
        logic [AMT_W-1:0] s_eff;
        logic [REP_W-1:0] rep;
    } fifo_entry_t;

    // A left rotate by n equals a right rotate by (8 - n) mod 8.
    function automatic logic [AMT_W-1:0] right_amt(input logic dir, input logic [AMT_W-1:0] amt);
        return (dir == DIR_LEFT) ? (AMT_W'(0) - amt) : amt;
    endfunction

endpackage

// File: rtl/bshift_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap at DEPTH, count is registered.
module bshift_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/bshift8_cmd_feeder.sv
// Command stage for an external 8-bit right-rotate shifter: queues commands,
// iterates passes through the shifter and returns the final word.
module bshift8_cmd_feeder
    import bshift_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_data,
    input  logic [2:0]               cmd_amt,
    input  logic                     cmd_dir,
    input  logic [1:0]               cmd_rep,
    output logic [7:0]               sh_in,
    output logic [2:0]               sh_s,
    input  logic [7:0]               sh_op,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROT_W-1:0] r_wdata;
    logic [ROT_W-1:0] w_wdata_nxt;
    logic [AMT_W-1:0] r_ws;
    logic [AMT_W-1:0] w_ws_nxt;
    logic [REP_W-1:0] r_wcnt;
    logic [REP_W-1:0] w_wcnt_nxt;
    logic [ROT_W-1:0] r_res_data;
    logic [ROT_W-1:0] w_res_data_nxt;
    logic             r_res_valid;
    logic             w_res_valid_nxt;

    fifo_entry_t      w_push_entry;
    fifo_entry_t      w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_push_entry = '{data: cmd_data, s_eff: right_amt(cmd_dir, cmd_amt), rep: cmd_rep};
    assign cmd_ready    = ~rst & ~w_full;
    assign w_push       = cmd_valid & cmd_ready;

    bshift_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (level)
    );

    // Work regs double as the shifter drive; they are zeroed whenever not in RUN.
    always_comb begin
        w_state_nxt     = r_state;
        w_wdata_nxt     = r_wdata;
        w_ws_nxt        = r_ws;
        w_wcnt_nxt      = r_wcnt;
        w_res_data_nxt  = r_res_data;
        w_res_valid_nxt = r_res_valid;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_wdata_nxt = w_head.data;
                    w_ws_nxt    = w_head.s_eff;
                    w_wcnt_nxt  = w_head.rep;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_wdata_nxt = sh_op;
                if (r_wcnt == '0) begin
                    w_res_data_nxt  = sh_op;
                    w_res_valid_nxt = 1'b1;
                    w_wdata_nxt     = '0;
                    w_ws_nxt        = '0;
                    w_state_nxt     = DONE;
                end else begin
                    w_wcnt_nxt = r_wcnt - REP_W'(1);
                end
            end
            DONE: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wdata     <= '0;
            r_ws        <= '0;
            r_wcnt      <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wdata     <= w_wdata_nxt;
            r_ws        <= w_ws_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    assign sh_in     = r_wdata;
    assign sh_s      = r_ws;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign busy      = (r_state != IDLE) | (level != '0);

endmodule
